// File: rtl/obi_mux_pkg.sv
// ============================================================================
// Module : obi_mux_pkg
// Brief  : Shared OBI request/response struct macros and index-width helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef OBI_MUX_PKG_MACROS
`define OBI_MUX_PKG_MACROS
`define OBI_REQ_T(AW, DW, IW) struct packed { logic [(AW)-1:0] addr; logic we; logic [(DW)/8-1:0] be; logic [(DW)-1:0] wdata; logic [(IW)-1:0] aid; }
`define OBI_RSP_T(DW, IW) struct packed { logic [(DW)-1:0] rdata; logic [(IW)-1:0] rid; }
`endif

package obi_mux_pkg;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/obi_mux_route_fifo.sv
// ============================================================================
// Module : obi_mux_route_fifo
// Brief  : Synchronous fall-through FIFO holding the master index of each
//          outstanding slave transaction.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module obi_mux_route_fifo #(
   parameter int unsigned Width = 1,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned c_ptr_w = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned c_cnt_w = $clog2(Depth + 1);

   logic [Width-1:0]   r_mem [Depth];
   logic [c_ptr_w-1:0] r_wptr;
   logic [c_ptr_w-1:0] r_rptr;
   logic [c_cnt_w-1:0] r_cnt;
   logic               w_push;
   logic               w_pop;

   function automatic logic [c_ptr_w-1:0] nxt(input logic [c_ptr_w-1:0] p);
      return (p == c_ptr_w'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (r_cnt == c_cnt_w'(Depth));
   assign empty_o = (r_cnt == '0);
   assign head_o  = r_mem[r_rptr];
   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= nxt(r_wptr);
         if (w_pop)  r_rptr <= nxt(r_rptr);
         if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
         else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      end
   end

   // Storage needs no reset: pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= data_i;
   end

endmodule

`default_nettype wire

// File: rtl/obi_mux.sv
// ============================================================================
// Module : obi_mux
// Brief  : N-to-1 OBI request multiplexer with in-order response routing.
//          Define OBI_MUX_RR_EN for round-robin, otherwise fixed priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module obi_mux
   import obi_mux_pkg::*;
#(
   parameter int unsigned NumMasters     = 2,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned IdWidth        = 1,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NumMasters-1:0]             m_req_i,
   output logic [NumMasters-1:0]             m_gnt_o,
   input  logic [NumMasters*AddrWidth-1:0]   m_addr_i,
   input  logic [NumMasters-1:0]             m_we_i,
   input  logic [NumMasters*DataWidth/8-1:0] m_be_i,
   input  logic [NumMasters*DataWidth-1:0]   m_wdata_i,
   input  logic [NumMasters*IdWidth-1:0]     m_aid_i,
   output logic [NumMasters-1:0]             m_rvalid_o,
   input  logic [NumMasters-1:0]             m_rready_i,
   output logic [NumMasters*DataWidth-1:0]   m_rdata_o,
   output logic [NumMasters*IdWidth-1:0]     m_rid_o,
   output logic                              s_req_o,
   input  logic                              s_gnt_i,
   output logic [AddrWidth-1:0]              s_addr_o,
   output logic                              s_we_o,
   output logic [DataWidth/8-1:0]            s_be_o,
   output logic [DataWidth-1:0]              s_wdata_o,
   output logic [IdWidth-1:0]                s_aid_o,
   input  logic                              s_rvalid_i,
   output logic                              s_rready_o,
   input  logic [DataWidth-1:0]              s_rdata_i,
   input  logic [IdWidth-1:0]                s_rid_i
);

   localparam int unsigned c_idx_w = idx_width(NumMasters);
   localparam int unsigned c_bw    = DataWidth / 8;

   typedef `OBI_REQ_T(AddrWidth, DataWidth, IdWidth) req_t;
   typedef `OBI_RSP_T(DataWidth, IdWidth) rsp_t;

   req_t               w_req [NumMasters];
   req_t               w_sreq;
   rsp_t               w_rsp;
   logic [c_idx_w-1:0] w_pick;
   logic [c_idx_w-1:0] w_sel;
   logic [c_idx_w-1:0] w_head;
   logic [c_idx_w-1:0] r_sel_q;
   logic               r_lock;
   logic               w_full;
   logic               w_empty;
   logic               w_acc;
   logic               w_pop;

   for (genvar g = 0; g < NumMasters; g++) begin : g_unpack
      assign w_req[g] = '{addr:  m_addr_i[g*AddrWidth +: AddrWidth],
                          we:    m_we_i[g],
                          be:    m_be_i[g*c_bw +: c_bw],
                          wdata: m_wdata_i[g*DataWidth +: DataWidth],
                          aid:   m_aid_i[g*IdWidth +: IdWidth]};
   end

`ifdef OBI_MUX_RR_EN
   logic [c_idx_w-1:0] r_ptr;
   logic               w_found;
   int                 w_idx;

   always_comb begin
      w_pick  = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int i = 0; i < int'(NumMasters); i++) begin
         w_idx = (int'(r_ptr) + i) % int'(NumMasters);
         if (!w_found && m_req_i[w_idx]) begin
            w_found = 1'b1;
            w_pick  = c_idx_w'(w_idx);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)      r_ptr <= '0;
      else if (w_acc) r_ptr <= (w_sel == c_idx_w'(NumMasters - 1)) ? '0 : w_sel + 1'b1;
   end
`else
   always_comb begin
      w_pick = '0;
      for (int i = int'(NumMasters) - 1; i >= 0; i--) begin
         if (m_req_i[i]) w_pick = c_idx_w'(i);
      end
   end
`endif

   // A stalled address phase keeps its master until the slave accepts it.
   assign w_sel   = r_lock ? r_sel_q : w_pick;
   assign w_sreq  = w_req[w_sel];
   assign s_req_o = m_req_i[w_sel] && !w_full;
   assign w_acc   = s_req_o && s_gnt_i;

   assign s_addr_o  = w_sreq.addr;
   assign s_we_o    = w_sreq.we;
   assign s_be_o    = w_sreq.be;
   assign s_wdata_o = w_sreq.wdata;
   assign s_aid_o   = w_sreq.aid;

   always_comb begin
      m_gnt_o        = '0;
      m_gnt_o[w_sel] = w_acc;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lock  <= 1'b0;
         r_sel_q <= '0;
      end else if (s_req_o && !s_gnt_i) begin
         r_lock  <= 1'b1;
         r_sel_q <= w_sel;
      end else if (w_acc) begin
         r_lock  <= 1'b0;
      end
   end

   obi_mux_route_fifo #(
      .Width (c_idx_w),
      .Depth (MaxOutstanding)
   ) u_route_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_acc),
      .data_i  (w_sel),
      .pop_i   (w_pop),
      .head_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   assign s_rready_o = m_rready_i[w_head] && !w_empty;
   assign w_pop      = s_rvalid_i && s_rready_o;

   always_comb begin
      m_rvalid_o         = '0;
      m_rvalid_o[w_head] = s_rvalid_i && !w_empty;
   end

   assign w_rsp     = '{rdata: s_rdata_i, rid: s_rid_i};
   assign m_rdata_o = {NumMasters{w_rsp.rdata}};
   assign m_rid_o   = {NumMasters{w_rsp.rid}};

`ifndef SYNTHESIS
   a_no_stray_rvalid : assert property (@(posedge clk_i) disable iff (rst_i)
                                        !(s_rvalid_i && w_empty));
`endif

endmodule

`default_nettype wire

// File: tb/tb_obi_mux.sv
// ============================================================================
// Module : tb_obi_mux
// Brief  : Self-checking bench for obi_mux (2 masters, 2 outstanding).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_obi_mux;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 1;
   localparam int MO = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      m_req, m_gnt, m_we, m_rvalid, m_rready;
   logic [N*AW-1:0]   m_addr;
   logic [N*DW/8-1:0] m_be;
   logic [N*DW-1:0]   m_wdata, m_rdata;
   logic [N*IW-1:0]   m_aid, m_rid;
   logic              s_req, s_gnt, s_we, s_rvalid, s_rready;
   logic [AW-1:0]     s_addr;
   logic [DW/8-1:0]   s_be;
   logic [DW-1:0]     s_wdata, s_rdata;
   logic [IW-1:0]     s_aid, s_rid;

   int n_checks = 0;
   int n_errors = 0;
   int q[$];

   always #5 clk = ~clk;

   obi_mux #(
      .NumMasters(N), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxOutstanding(MO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
      .m_be_i(m_be), .m_wdata_i(m_wdata), .m_aid_i(m_aid),
      .m_rvalid_o(m_rvalid), .m_rready_i(m_rready), .m_rdata_o(m_rdata), .m_rid_o(m_rid),
      .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we),
      .s_be_o(s_be), .s_wdata_o(s_wdata), .s_aid_o(s_aid),
      .s_rvalid_i(s_rvalid), .s_rready_o(s_rready), .s_rdata_i(s_rdata), .s_rid_i(s_rid)
   );

   typedef struct {
      logic [1:0] req;
      logic       sgnt;
      logic       sreq;
      int         mst_fp;
      int         mst_rr;
      logic [1:0] gnt_fp;
      logic [1:0] gnt_rr;
   } vec_t;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [69:0] exp_bundle(input int k);
      if (k == 1) return {32'h0000_0200, 1'b0, 4'hC, 32'hB1B1_B1B1, 1'b1};
      return {32'h0000_0100, 1'b1, 4'h3, 32'hA0A0_A0A0, 1'b0};
   endfunction

   task automatic idle();
      @(negedge clk);
      m_req    = 2'b00;
      s_gnt    = 1'b0;
      s_rvalid = 1'b0;
      #1;
   endtask

   // One cycle: drive, check address and response paths against the
   // route scoreboard, then update it with the handshakes of this cycle.
   task automatic cyc(input logic [1:0] req, input logic sgnt, input logic rv,
                      input logic [1:0] rr, input logic exp_sreq,
                      input logic [1:0] exp_gnt, input int exp_mst,
                      input logic [31:0] rd);
      logic       drive_rv;
      logic [1:0] exp_rv;
      logic       exp_rr;
      @(negedge clk);
      drive_rv = rv && (q.size() > 0);
      m_req    = req;
      s_gnt    = sgnt;
      s_rvalid = drive_rv;
      m_rready = rr;
      s_rdata  = rd;
      s_rid    = 1'($urandom);
      exp_rv   = drive_rv ? (2'b01 << q[0]) : 2'b00;
      exp_rr   = (q.size() > 0) ? rr[q[0]] : 1'b0;
      #1;
      check("s_req", s_req, exp_sreq);
      check("m_gnt", m_gnt, exp_gnt);
      if (exp_sreq) check("s_addr_phase", {s_addr, s_we, s_be, s_wdata, s_aid}, exp_bundle(exp_mst));
      check("m_rvalid", m_rvalid, exp_rv);
      check("s_rready", s_rready, exp_rr);
      if (drive_rv) check("rsp_bcast", {m_rdata, m_rid}, {s_rdata, s_rdata, s_rid, s_rid});
      if (drive_rv && exp_rr) void'(q.pop_front());
      if (exp_sreq && sgnt) q.push_back(exp_mst);
   endtask

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{2'b00, 1'b1, 1'b0, 0, 0, 2'b00, 2'b00};
      tbl[1]  = '{2'b01, 1'b1, 1'b1, 0, 0, 2'b01, 2'b01};
      tbl[2]  = '{2'b11, 1'b1, 1'b1, 0, 1, 2'b01, 2'b10};
      tbl[3]  = '{2'b11, 1'b1, 1'b1, 0, 0, 2'b01, 2'b01};
      tbl[4]  = '{2'b11, 1'b1, 1'b1, 0, 1, 2'b01, 2'b10};
      tbl[5]  = '{2'b11, 1'b1, 1'b1, 0, 0, 2'b01, 2'b01};
      tbl[6]  = '{2'b10, 1'b0, 1'b1, 1, 1, 2'b00, 2'b00};
      tbl[7]  = '{2'b11, 1'b0, 1'b1, 1, 1, 2'b00, 2'b00};
      tbl[8]  = '{2'b11, 1'b0, 1'b1, 1, 1, 2'b00, 2'b00};
      tbl[9]  = '{2'b11, 1'b1, 1'b1, 1, 1, 2'b10, 2'b10};
      tbl[10] = '{2'b11, 1'b1, 1'b1, 0, 0, 2'b01, 2'b01};
      tbl[11] = '{2'b00, 1'b0, 1'b0, 0, 0, 2'b00, 2'b00};

      m_addr   = {32'h0000_0200, 32'h0000_0100};
      m_we     = 2'b01;
      m_be     = {4'hC, 4'h3};
      m_wdata  = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
      m_aid    = 2'b10;
      s_rdata  = '0;
      s_rid    = '0;

      // Reset state; master 1 requesting while reset is held.
      rst      = 1'b1;
      m_req    = 2'b10;
      s_gnt    = 1'b0;
      s_rvalid = 1'b0;
      m_rready = 2'b11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_m_gnt", m_gnt, 2'b00);
      check("rst_m_rvalid", m_rvalid, 2'b00);
      check("rst_s_rready", s_rready, 1'b0);
      check("rst_s_req_follows", s_req, 1'b1);
      check("rst_cnt", dut.u_route_fifo.r_cnt, 2'd0);
      @(negedge clk);
      rst   = 1'b0;
      m_req = 2'b00;

      // Arbitration and lock sequence.
      for (int i = 0; i < 12; i++) begin
`ifdef OBI_MUX_RR_EN
         cyc(tbl[i].req, tbl[i].sgnt, 1'b1, 2'b11, tbl[i].sreq, tbl[i].gnt_rr, tbl[i].mst_rr, $urandom);
`else
         cyc(tbl[i].req, tbl[i].sgnt, 1'b1, 2'b11, tbl[i].sreq, tbl[i].gnt_fp, tbl[i].mst_fp, $urandom);
`endif
      end
      idle();

      // Single read from master 0 and its response.
      cyc(2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 0, 32'h0);
      cyc(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 0, 32'hDEAD_BEEF);
      check("read_rdata", m_rdata, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
      idle();
      check("read_cnt", dut.u_route_fifo.r_cnt, 2'd0);

      // Fill to MaxOutstanding, confirm stall even during a pop, then resume.
      cyc(2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 0, 32'h0);
      cyc(2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 0, 32'h0);
      cyc(2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 0, 32'h0);
      check("full_cnt", dut.u_route_fifo.r_cnt, 2'd2);
      cyc(2'b01, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 0, $urandom);
      cyc(2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 0, 32'h0);
      cyc(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 0, $urandom);
      cyc(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 0, $urandom);
      idle();

      // Interleaved M0, M1, M0 with a response stall from master 1.
      cyc(2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 0, 32'h0);
      cyc(2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1, 32'h0);
      cyc(2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 0, $urandom);
      cyc(2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 2'b01, 0, $urandom);
      cyc(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 0, $urandom);
      cyc(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 0, $urandom);
      idle();
      check("drain_cnt", dut.u_route_fifo.r_cnt, 2'd0);

      // Reset with two transactions in flight.
      cyc(2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 0, 32'h0);
      cyc(2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1, 32'h0);
      idle();
      check("pre_rst_cnt", dut.u_route_fifo.r_cnt, 2'd2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      m_rready = 2'b11;
      q.delete();
      #1;
      check("mid_rst_cnt", dut.u_route_fifo.r_cnt, 2'd0);
      check("mid_rst_m_rvalid", m_rvalid, 2'b00);
      check("mid_rst_s_rready", s_rready, 1'b0);
`ifdef OBI_MUX_RR_EN
      check("mid_rst_ptr", dut.r_ptr, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
